// File: rtl/button_event_scheduler.sv
// Shared debounce, short/long press classification and round-robin event
// queue for a bank of push-buttons, drained over a valid/ready interface.
module button_event_scheduler #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 250000,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_raw,
    input  logic                     evt_ready,
    input  logic                     clr_overflow,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    output logic [N_BTN-1:0]         btn_state,
    output logic                     overflow
);

    localparam int ID_W = $clog2(N_BTN);
    localparam int TW   = $clog2(TICK_DIV);
    localparam int SW   = $clog2(STABLE_TICKS + 1);
    localparam int HW   = $clog2(LONG_TICKS + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    // ---------------- tick generator ----------------
    logic [TW-1:0] tick_cnt_q;
    logic          tick;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // ---------------- synchroniser ----------------
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // ---------------- stability filter ----------------
    logic [SW-1:0]    stab_q [N_BTN];
    logic [SW-1:0]    stab_d [N_BTN];
    logic [N_BTN-1:0] state_q;
    logic [N_BTN-1:0] state_d;
    logic [N_BTN-1:0] prev_q;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            stab_d[i]  = stab_q[i];
            state_d[i] = state_q[i];
            if (tick) begin
                if (sync2_q[i] == state_q[i]) begin
                    stab_d[i] = '0;
                end else if (stab_q[i] == SW'(STABLE_TICKS - 1)) begin
                    state_d[i] = sync2_q[i];
                    stab_d[i]  = '0;
                end else begin
                    stab_d[i] = stab_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                stab_q[i] <= '0;
            end
            state_q <= '0;
            prev_q  <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                stab_q[i] <= stab_d[i];
            end
            state_q <= state_d;
            prev_q  <= state_q;
        end
    end

    // ---------------- press classification ----------------
    logic [HW-1:0]    hold_q [N_BTN];
    logic [HW-1:0]    hold_d [N_BTN];
    logic [N_BTN-1:0] lsent_q;
    logic [N_BTN-1:0] lsent_d;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] ev;
    logic [N_BTN-1:0] ev_type;

    assign rise = state_q & ~prev_q;
    assign fall = ~state_q & prev_q;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            hold_d[i]  = hold_q[i];
            lsent_d[i] = lsent_q[i];
            ev[i]      = 1'b0;
            ev_type[i] = 1'b0;
            if (rise[i]) begin
                hold_d[i]  = '0;
                lsent_d[i] = 1'b0;
            end else if (state_q[i]) begin
                if (tick && hold_q[i] != HW'(LONG_TICKS)) begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
                if (hold_q[i] == HW'(LONG_TICKS) && !lsent_q[i]) begin
                    ev[i]      = 1'b1;
                    ev_type[i] = 1'b1;
                    lsent_d[i] = 1'b1;
                end
            end else if (fall[i] && !lsent_q[i]) begin
                ev[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= '0;
            end
            lsent_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= hold_d[i];
            end
            lsent_q <= lsent_d;
        end
    end

    // ---------------- FIFO state ----------------
    logic [ID_W:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [CW-1:0]   count_q;
    logic            pop;
    logic            can_push;

    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;
    assign can_push  = (count_q != CW'(FIFO_DEPTH)) || pop;

    // ---------------- round-robin arbiter ----------------
    logic [N_BTN-1:0] pend_q;
    logic [N_BTN-1:0] pend_d;
    logic [N_BTN-1:0] ptype_q;
    logic [N_BTN-1:0] ptype_d;
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  rr_d;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic [N_BTN-1:0] gnt;

    always_comb begin : arb
        int j;
        logic [ID_W-1:0] jj;
        j       = 0;
        jj      = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int k = 0; k < N_BTN; k++) begin
            j = int'(rr_q) + k;
            if (j >= N_BTN) begin
                j = j - N_BTN;
            end
            jj = ID_W'(j);
            if (!gnt_any && pend_q[jj] && can_push) begin
                gnt_any = 1'b1;
                gnt_idx = jj;
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
        rr_d = rr_q;
        if (gnt_any) begin
            rr_d = (gnt_idx == ID_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ---------------- pending stage / overflow ----------------
    logic drop;
    logic ov_q;
    logic ov_d;

    // a grant frees the slot in the same clk, so a coinciding event replaces it
    always_comb begin
        drop = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            pend_d[i]  = pend_q[i] & ~gnt[i];
            ptype_d[i] = ptype_q[i];
            if (ev[i]) begin
                if (pend_q[i] && !gnt[i]) begin
                    drop = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    ptype_d[i] = ev_type[i];
                end
            end
        end
        ov_d = ov_q;
        if (drop) begin
            ov_d = 1'b1;
        end else if (clr_overflow) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            ptype_q <= '0;
            rr_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            rr_q    <= rr_d;
            ov_q    <= ov_d;
        end
    end

    // ---------------- FIFO update ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (gnt_any) begin
                mem_q[wr_q] <= {gnt_idx, ptype_q[gnt_idx]};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (gnt_any && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!gnt_any && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign evt_id    = mem_q[rd_q][ID_W:1];
    assign evt_long  = mem_q[rd_q][0];
    assign btn_state = state_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler: directed button sequences
// push expected events; a monitor pops and compares on each handshake.
module tb_button_event_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = '0;
    logic       evt_ready = 1'b1;
    logic       clr_overflow = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_long;
    logic [3:0] btn_state;
    logic       overflow;

    typedef struct {
        logic [1:0] id;
        logic       lng;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  errors = 0;
    int  checks = 0;

    button_event_scheduler #(
        .N_BTN(4), .TICK_DIV(4), .STABLE_TICKS(3),
        .LONG_TICKS(10), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .evt_ready(evt_ready), .clr_overflow(clr_overflow),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_long(evt_long),
        .btn_state(btn_state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got id=%0d long=%0d, required none",
                         evt_id, evt_long);
            end else begin
                mon_e = exp_q.pop_front();
                if (evt_id !== mon_e.id || evt_long !== mon_e.lng) begin
                    errors++;
                    $display("FAIL evt_order: got id=%0d long=%0d, required id=%0d long=%0d",
                             evt_id, evt_long, mon_e.id, mon_e.lng);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic exp_ev(input logic [1:0] id, input logic lng);
        ev_t e;
        e.id  = id;
        e.lng = lng;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic tap(input logic [3:0] mask);
        btn_raw = mask;
        clks(30);
        btn_raw = '0;
    endtask

    initial begin
        // reset, then reset again mid-operation with button 0 held
        clks(3);
        rst = 1'b0;
        btn_raw = 4'b0001;
        clks(20);
        chk("pre_reset_state", btn_state, 4'b0001);
        rst = 1'b1;
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_state", btn_state, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_id_long", {evt_id, evt_long}, 0);
        clks(2);
        rst = 1'b0;
        clks(8);
        chk("filter_not_early", btn_state, 0);
        clks(8);
        chk("filter_accept", btn_state, 4'b0001);
        btn_raw = '0;
        exp_ev(0, 0);
        drain("reset_release_evt", 60);

        // bounce rejection on button 1
        for (int k = 0; k < 20; k++) begin
            btn_raw[1] = ~btn_raw[1];
            clks(5);
            chk("bounce_state", btn_state[1], 0);
        end
        clks(20);
        chk("bounce_after", btn_state, 0);
        btn_raw[1] = 1'b1;
        clks(30);
        chk("held_state1", btn_state, 4'b0010);
        btn_raw[1] = 1'b0;
        exp_ev(1, 0);
        clks(30);
        drain("bounce_short_evt", 30);

        // long press on button 2
        btn_raw[2] = 1'b1;
        exp_ev(2, 1);
        clks(45);
        chk("long_not_early", exp_q.size(), 1);
        clks(25);
        chk("long_fired", exp_q.size(), 0);
        clks(170);
        chk("long_held_state", btn_state, 4'b0100);
        btn_raw[2] = 1'b0;
        clks(40);
        chk("long_released", btn_state, 0);

        // round robin: rr=1 after a button-0 event
        tap(4'b0001);
        exp_ev(0, 0);
        drain("rr_prep", 80);
        tap(4'b1011);
        exp_ev(1, 0);
        exp_ev(3, 0);
        exp_ev(0, 0);
        drain("rr_three", 80);
        tap(4'b0011);
        exp_ev(1, 0);
        exp_ev(0, 0);
        drain("rr_end_at_1", 80);

        // backpressure and overflow
        evt_ready = 1'b0;
        tap(4'b1111);
        exp_ev(1, 0);
        exp_ev(2, 0);
        exp_ev(3, 0);
        exp_ev(0, 0);
        clks(30);
        chk("bp_valid", evt_valid, 1);
        chk("bp_head", {evt_id, evt_long}, {2'd1, 1'b0});
        tap(4'b0001);
        exp_ev(0, 0);
        clks(30);
        chk("bp_pend_no_ovf", overflow, 0);
        tap(4'b0001);
        clks(30);
        chk("bp_drop_ovf", overflow, 1);
        chk("bp_head_stable", {evt_id, evt_long}, {2'd1, 1'b0});
        evt_ready = 1'b1;
        drain("bp_drain5", 40);
        chk("ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        clks(1);
        clr_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // full FIFO with simultaneous push and pop
        evt_ready = 1'b0;
        tap(4'b1111);
        exp_ev(1, 0);
        exp_ev(2, 0);
        exp_ev(3, 0);
        exp_ev(0, 0);
        clks(30);
        tap(4'b0001);
        exp_ev(0, 0);
        clks(30);
        evt_ready = 1'b1;
        clks(1);
        evt_ready = 1'b0;
        chk("pp_valid", evt_valid, 1);
        chk("pp_head", {evt_id, evt_long}, {2'd2, 1'b0});
        clks(5);
        chk("pp_head_hold", evt_id, 2);
        tap(4'b0001);
        exp_ev(0, 0);
        clks(30);
        chk("pp_pend_freed", overflow, 0);
        evt_ready = 1'b1;
        drain("pp_drain", 40);
        clks(2);
        chk("final_empty", evt_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Shared debounce-and-event engine for N push-buttons. One slow tick generator is shared by all buttons. Each button gets a synchroniser, a stability filter and short/long-press classification.
- Per-button events are arbitrated round-robin into a small FIFO. The FIFO drains to the UI/control FSM over a valid/ready interface.
- Replaces per-button debouncer instances at the top level.

Parameters:
- N_BTN, 4, number of buttons (2..8).
- TICK_DIV, 250000, clk cycles per sample tick (≥2).
- STABLE_TICKS, 4, consecutive ticks a raw level must hold before it is accepted (1..15).
- LONG_TICKS, 200, ticks held before a press counts as long (2..1023).
- FIFO_DEPTH, 4, event queue depth (power of two, ≥2).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- btn_raw  in  N_BTN  raw button levels, asynchronous, 1 = pressed.
- evt_ready  in  1  consumer accepts the head event.
- clr_overflow  in  1  clears the overflow flag.
- evt_valid  out  1  FIFO non-empty.
- evt_id  out  clog2(N_BTN)  button index of the head event.
- evt_long  out  1  head event type: 1 = long press, 0 = short press.
- btn_state  out  N_BTN  debounced button levels.
- overflow  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset (async, asserted): all counters, synchronisers, btn_state, pending flags, FIFO pointers and count go to 0; rr pointer = 0; overflow = 0; evt_valid = 0. Outputs are valid in the first clk after rst deasserts.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick = 1 for exactly one clk when count == TICK_DIV-1.
- Synchroniser: btn_raw[i] passes through 2 flops to give s[i]. All filter logic uses s[i] only.
- Stability filter, evaluated per button on tick only:
  - If s[i] == btn_state[i], stab_cnt[i] is cleared.
  - Otherwise stab_cnt[i] increments. When it reaches STABLE_TICKS, btn_state[i] takes s[i] and stab_cnt[i] is cleared, in the same clk.
  - Any bounce resets the count.
- Press classification, per button, with hold_cnt[i] saturating at LONG_TICKS:
  - Rising edge of btn_state[i]: hold_cnt[i] = 0, long_sent[i] = 0.
  - While btn_state[i] = 1, hold_cnt[i] increments on each tick.
  - When hold_cnt[i] reaches LONG_TICKS and long_sent[i] = 0: raise a long event (type 1) and set long_sent[i] = 1. This fires while the button is still held.
  - Falling edge of btn_state[i]: if long_sent[i] = 0, raise a short event (type 0); if long_sent[i] = 1, raise nothing.
- Pending stage: each raised event sets pend[i] and pend_type[i] at the next clk edge.
  - If pend[i] is already set and is not being granted that same clk, the new event is dropped and overflow = 1.
  - If the grant and a new event for the same button coincide, the new event replaces the old pending entry; no overflow.
- Arbiter:
  - Each clk, with the FIFO able to accept, grant the first pending button at or after rr, modulo N_BTN.
  - Write {i, pend_type[i]} into the FIFO, clear pend[i], and set rr = i+1 mod N_BTN.
  - No pending button, or FIFO unable to accept: no grant, rr holds.
- FIFO:
  - Pop occurs when evt_valid & evt_ready.
  - Push is allowed when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop happens in the same clk.
  - Simultaneous push and pop: count is unchanged, and the head advances correctly.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_id and evt_long come from the head entry. They hold stable while evt_valid & !evt_ready, and are don't-care when evt_valid = 0.
  - When the FIFO is full, events wait in pend; they are dropped only via the pending rule above.
- Latency: btn_state edge at clk T → pend set at T+1 → FIFO write at T+2 → evt_valid = 1 after edge T+2 (FIFO previously empty, no contention).
- overflow: cleared by clr_overflow. If clr_overflow and a new drop coincide, the set wins.

Test Plan (sim params: TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10, FIFO_DEPTH=4, N_BTN=4):
- Reset and idle: assert rst mid-operation with btn_raw=4'b0001 held → all outputs 0 immediately. After release, with raw still high, btn_state[0] = 1 after sync + 3 ticks (≈14 clks).
- Bounce rejection: toggle btn_raw[1] every 5 clks for 100 clks → btn_state[1] stays 0, no event. Then hold high for 30 clks, release for 30 clks → exactly one event {id=1, long=0}.
- Long press: hold btn_raw[2] for 60 ticks → one event {id=2, long=1} about 10 ticks after btn_state rises. Release → no further event.
- Round-robin: buttons 0, 1 and 3 release in the same clk with rr=1 → FIFO order is ids 1, 3, 0; rr ends at 1.
- Backpressure/overflow: evt_ready=0, then generate 4 events on buttons 0..3 plus a second short event on button 0 → FIFO full. Button 0's second event waits in pend. A third button-0 event → overflow = 1 and that event is dropped. Drain with evt_ready=1 → 5 events out, in FIFO order. Pulse clr_overflow → overflow = 0.
- Full with simultaneous push/pop: FIFO full, one pending event, evt_ready=1 for 1 clk → pop and push in the same clk; count stays 4; head advances to the next entry.
